// File: rtl/winograd_tile_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : winograd_tile_scheduler_if
// Brief    : Control, fetch and PE-issue signals of the Winograd tile scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface winograd_tile_scheduler_if #(
    parameter int IDX_W = 9,
    parameter int OD_W  = 8
);
    logic             start;
    logic [IDX_W-1:0] cfg_height;
    logic [IDX_W-1:0] cfg_width;
    logic [OD_W-1:0]  cfg_od;
    logic             cfg_size_type;
    logic             busy;
    logic             done;
    logic             err_cfg;
    logic             wt_req;
    logic [OD_W-1:0]  wt_od;
    logic             wt_ack;
    logic             in_req;
    logic [IDX_W-1:0] in_h_idx;
    logic [IDX_W-1:0] in_w_idx;
    logic             in_ack;
    logic             pe_input_valid;
    logic             pe_weight_valid;
    logic             pe_ready;
    logic [IDX_W-1:0] pe_height_index;
    logic [IDX_W-1:0] pe_width_index;
    logic [OD_W-1:0]  pe_od;

    // Scheduler side
    modport master (
        input  start, cfg_height, cfg_width, cfg_od, cfg_size_type,
        input  wt_ack, in_ack, pe_ready,
        output busy, done, err_cfg,
        output wt_req, wt_od, in_req, in_h_idx, in_w_idx,
        output pe_input_valid, pe_weight_valid,
        output pe_height_index, pe_width_index, pe_od
    );

    // Layer control, buffers and PE chain side
    modport slave (
        output start, cfg_height, cfg_width, cfg_od, cfg_size_type,
        output wt_ack, in_ack, pe_ready,
        input  busy, done, err_cfg,
        input  wt_req, wt_od, in_req, in_h_idx, in_w_idx,
        input  pe_input_valid, pe_weight_valid,
        input  pe_height_index, pe_width_index, pe_od
    );
endinterface
`default_nettype wire

// File: rtl/winograd_tile_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : winograd_tile_scheduler
// Brief    : Walks od / tile-row / tile-column, fetches weight and input tiles
//            and issues each pair to the PE chain head. Optional macro
//            SCHED_PERF_CNT_EN adds perf_tiles / perf_stall counters.
// Revision : 1.0 - initial release
// ============================================================================
module winograd_tile_scheduler #(
    parameter int IDX_W = 9,
    parameter int OD_W  = 8
) (
    input  wire logic                 clk,
    input  wire logic                 reset,
    winograd_tile_scheduler_if.master bus
`ifdef SCHED_PERF_CNT_EN
    ,
    output logic [31:0]               perf_tiles,
    output logic [31:0]               perf_stall
`endif
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD_W   = 3'd1,
        S_FETCH_IN = 3'd2,
        S_ISSUE    = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    localparam logic [IDX_W:0] c_step_3x3 = (IDX_W+1)'(4);
    localparam logic [IDX_W:0] c_step_1x1 = (IDX_W+1)'(6);

    state_t           state_q, state_d;
    logic [OD_W-1:0]  od_q, od_d;
    logic [IDX_W-1:0] h_q, h_d;
    logic [IDX_W-1:0] w_q, w_d;
    logic [IDX_W-1:0] height_q, height_d;
    logic [IDX_W-1:0] width_q, width_d;
    logic [OD_W-1:0]  cfg_od_q, cfg_od_d;
    logic             size_type_q, size_type_d;
    logic             err_q, err_d;

    logic             w_start_accept;
    logic [IDX_W:0]   w_step;
    logic [IDX_W:0]   w_h_next;
    logic [IDX_W:0]   w_w_next;
    logic [OD_W:0]    w_od_next;
    logic             w_h_last;
    logic             w_w_last;
    logic             w_od_last;

    assign w_start_accept = (state_q == S_IDLE) && bus.start;
    assign w_step         = size_type_q ? c_step_3x3 : c_step_1x1;

    // One extra bit keeps the last-tile test exact at the 511 maximum
    assign w_h_next  = {1'b0, h_q} + w_step;
    assign w_w_next  = {1'b0, w_q} + w_step;
    assign w_od_next = {1'b0, od_q} + (OD_W+1)'(1);
    assign w_h_last  = w_h_next >= {1'b0, height_q};
    assign w_w_last  = w_w_next >= {1'b0, width_q};
    assign w_od_last = w_od_next >= {1'b0, cfg_od_q};

    always_comb begin
        state_d     = state_q;
        od_d        = od_q;
        h_d         = h_q;
        w_d         = w_q;
        height_d    = height_q;
        width_d     = width_q;
        cfg_od_d    = cfg_od_q;
        size_type_d = size_type_q;
        err_d       = err_q;
        case (state_q)
            S_IDLE: begin
                if (w_start_accept) begin
                    height_d    = bus.cfg_height;
                    width_d     = bus.cfg_width;
                    cfg_od_d    = bus.cfg_od;
                    size_type_d = bus.cfg_size_type;
                    od_d        = '0;
                    h_d         = '0;
                    w_d         = '0;
                    if ((bus.cfg_height == '0) || (bus.cfg_width == '0) || (bus.cfg_od == '0)) begin
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        err_d   = 1'b0;
                        state_d = S_LOAD_W;
                    end
                end
            end
            S_LOAD_W: begin
                if (bus.wt_ack) state_d = S_FETCH_IN;
            end
            S_FETCH_IN: begin
                if (bus.in_ack) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (bus.pe_ready) begin
                    if (!w_w_last) begin
                        w_d     = w_w_next[IDX_W-1:0];
                        state_d = S_FETCH_IN;
                    end else if (!w_h_last) begin
                        w_d     = '0;
                        h_d     = w_h_next[IDX_W-1:0];
                        state_d = S_FETCH_IN;
                    end else if (!w_od_last) begin
                        w_d     = '0;
                        h_d     = '0;
                        od_d    = w_od_next[OD_W-1:0];
                        state_d = S_LOAD_W;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                err_d   = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            od_q        <= '0;
            h_q         <= '0;
            w_q         <= '0;
            height_q    <= '0;
            width_q     <= '0;
            cfg_od_q    <= '0;
            size_type_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            od_q        <= od_d;
            h_q         <= h_d;
            w_q         <= w_d;
            height_q    <= height_d;
            width_q     <= width_d;
            cfg_od_q    <= cfg_od_d;
            size_type_q <= size_type_d;
            err_q       <= err_d;
        end
    end

    // Indices are gated so every output reads zero outside its own state
    assign bus.busy            = (state_q != S_IDLE);
    assign bus.done            = (state_q == S_DONE);
    assign bus.err_cfg         = (state_q == S_DONE) && err_q;
    assign bus.wt_req          = (state_q == S_LOAD_W);
    assign bus.wt_od           = (state_q == S_LOAD_W) ? od_q : '0;
    assign bus.in_req          = (state_q == S_FETCH_IN);
    assign bus.in_h_idx        = (state_q == S_FETCH_IN) ? h_q : '0;
    assign bus.in_w_idx        = (state_q == S_FETCH_IN) ? w_q : '0;
    assign bus.pe_input_valid  = (state_q == S_ISSUE);
    assign bus.pe_weight_valid = (state_q == S_ISSUE);
    assign bus.pe_height_index = (state_q == S_ISSUE) ? h_q : '0;
    assign bus.pe_width_index  = (state_q == S_ISSUE) ? w_q : '0;
    assign bus.pe_od           = (state_q == S_ISSUE) ? od_q : '0;

`ifdef SCHED_PERF_CNT_EN
    logic [31:0] perf_tiles_q, perf_tiles_d;
    logic [31:0] perf_stall_q, perf_stall_d;
    logic        w_stall;

    assign w_stall = ((state_q == S_LOAD_W)   && !bus.wt_ack) ||
                     ((state_q == S_FETCH_IN) && !bus.in_ack) ||
                     ((state_q == S_ISSUE)    && !bus.pe_ready);

    always_comb begin
        perf_tiles_d = perf_tiles_q;
        perf_stall_d = perf_stall_q;
        if (w_start_accept) begin
            perf_tiles_d = '0;
            perf_stall_d = '0;
        end else begin
            if ((state_q == S_ISSUE) && bus.pe_ready && (perf_tiles_q != '1))
                perf_tiles_d = perf_tiles_q + 32'd1;
            if (w_stall && (perf_stall_q != '1))
                perf_stall_d = perf_stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_tiles_q <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_tiles_q <= perf_tiles_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_tiles = perf_tiles_q;
    assign perf_stall = perf_stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_winograd_tile_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_winograd_tile_scheduler
// Brief    : Scoreboard bench for winograd_tile_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_winograd_tile_scheduler;

    localparam int IDX_W = 9;
    localparam int OD_W  = 8;

    typedef struct packed {
        logic [OD_W-1:0]  od;
        logic [IDX_W-1:0] h;
        logic [IDX_W-1:0] w;
    } tile_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    winograd_tile_scheduler_if #(.IDX_W(IDX_W), .OD_W(OD_W)) bus ();

`ifdef SCHED_PERF_CNT_EN
    logic [31:0] perf_tiles;
    logic [31:0] perf_stall;
`endif

    winograd_tile_scheduler #(.IDX_W(IDX_W), .OD_W(OD_W)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef SCHED_PERF_CNT_EN
        ,
        .perf_tiles (perf_tiles),
        .perf_stall (perf_stall)
`endif
    );

    tile_t exp_q[$];
    int    checks = 0;
    int    errors = 0;

    // Drives one layer, scoreboards every fetch and issue against the loop model
    task automatic run_layer(input int h, input int w, input int od, input bit st,
                             input int stall_issue, input int stall_len, input bit mid_start,
                             output int done_cycle, output int n_issue, output int n_req,
                             output bit err_at_done, output tile_t last_tile);
        int    step, cycle, rem, issue_idx;
        tile_t t, e;
        step = st ? 4 : 6;
        exp_q.delete();
        for (int o = 0; o < od; o++)
            for (int hh = 0; hh < h; hh += step)
                for (int ww = 0; ww < w; ww += step) begin
                    t.od = o[OD_W-1:0];
                    t.h  = hh[IDX_W-1:0];
                    t.w  = ww[IDX_W-1:0];
                    exp_q.push_back(t);
                end
        done_cycle = -1; n_issue = 0; n_req = 0; err_at_done = 1'b0; last_tile = '0;
        rem = stall_len; issue_idx = 0; cycle = 0;
        @(negedge clk);
        bus.cfg_height    = h[IDX_W-1:0];
        bus.cfg_width     = w[IDX_W-1:0];
        bus.cfg_od        = od[OD_W-1:0];
        bus.cfg_size_type = st;
        bus.start = 1'b1; bus.wt_ack = 1'b1; bus.in_ack = 1'b1; bus.pe_ready = 1'b1;
        while (cycle < 40000) begin
            @(negedge clk);
            cycle++;
            bus.start         = mid_start && (cycle == 3);
            bus.cfg_height    = IDX_W'($urandom);
            bus.cfg_width     = IDX_W'($urandom);
            bus.cfg_od        = OD_W'($urandom);
            bus.cfg_size_type = 1'($urandom);
            if (cycle == 1) begin
                checks++;
                if (bus.busy !== 1'b1) begin
                    errors++; $display("FAIL busy_cycle1 got %b need 1", bus.busy);
                end
            end
            if (bus.wt_req === 1'b1) begin
                n_req++;
                if (exp_q.size() > 0) begin
                    e = exp_q[0];
                    checks++;
                    if (bus.wt_od !== e.od) begin
                        errors++; $display("FAIL wt_od got %0d need %0d", bus.wt_od, e.od);
                    end
                end
            end
            if (bus.in_req === 1'b1) begin
                n_req++;
                if (exp_q.size() > 0) begin
                    e = exp_q[0];
                    checks++;
                    if ({bus.in_h_idx, bus.in_w_idx} !== {e.h, e.w}) begin
                        errors++;
                        $display("FAIL in_idx got h=%0d w=%0d need h=%0d w=%0d",
                                 bus.in_h_idx, bus.in_w_idx, e.h, e.w);
                    end
                end
            end
            if (bus.pe_input_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL extra_issue got od=%0d h=%0d w=%0d need none",
                                       bus.pe_od, bus.pe_height_index, bus.pe_width_index);
                    bus.pe_ready = 1'b1;
                end else begin
                    e = exp_q[0];
                    if ({bus.pe_weight_valid, bus.pe_od, bus.pe_height_index, bus.pe_width_index}
                        !== {1'b1, e.od, e.h, e.w}) begin
                        errors++;
                        $display("FAIL issue got wv=%b od=%0d h=%0d w=%0d need wv=1 od=%0d h=%0d w=%0d",
                                 bus.pe_weight_valid, bus.pe_od, bus.pe_height_index,
                                 bus.pe_width_index, e.od, e.h, e.w);
                    end
                    if ((issue_idx == stall_issue) && (rem > 0)) begin
                        bus.pe_ready = 1'b0;
                        rem--;
                    end else begin
                        bus.pe_ready = 1'b1;
                        last_tile = exp_q.pop_front();
                        issue_idx++;
                        n_issue++;
                    end
                end
            end else begin
                bus.pe_ready = 1'b1;
            end
            if (bus.done === 1'b1) begin
                done_cycle  = cycle;
                err_at_done = bus.err_cfg;
                break;
            end
        end
        bus.start = 1'b0;
        checks++;
        if (done_cycle < 0) begin
            errors++; $display("FAIL done_timeout got none need done");
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++; $display("FAIL missing_issues got %0d left need 0", exp_q.size());
        end
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.err_cfg} !== 3'b000) begin
            errors++; $display("FAIL after_done got busy/done/err=%b need 000",
                               {bus.busy, bus.done, bus.err_cfg});
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0; bus.wt_ack = 1'b0; bus.in_ack = 1'b0; bus.pe_ready = 1'b0;
        bus.cfg_height = '0; bus.cfg_width = '0; bus.cfg_od = '0; bus.cfg_size_type = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.err_cfg, bus.wt_req, bus.in_req,
             bus.pe_input_valid, bus.pe_weight_valid} !== 7'b0) begin
            errors++; $display("FAIL reset_ctrl got nonzero need 0");
        end
        checks++;
        if ({bus.wt_od, bus.in_h_idx, bus.in_w_idx, bus.pe_height_index,
             bus.pe_width_index, bus.pe_od} !== '0) begin
            errors++; $display("FAIL reset_idx got nonzero need 0");
        end
`ifdef SCHED_PERF_CNT_EN
        checks++;
        if ({perf_tiles, perf_stall} !== 64'd0) begin
            errors++; $display("FAIL reset_perf got %0d/%0d need 0/0", perf_tiles, perf_stall);
        end
`endif
        reset = 1'b0;
    endtask

    task automatic test_basic_3x3();
        int dc, ni, nr; bit er; tile_t lt;
        run_layer(8, 8, 2, 1'b1, -1, 0, 1'b1, dc, ni, nr, er, lt);
        checks++;
        if (dc != 19) begin errors++; $display("FAIL basic_done_cycle got %0d need 19", dc); end
        checks++;
        if (ni != 8) begin errors++; $display("FAIL basic_issues got %0d need 8", ni); end
        checks++;
        if (er !== 1'b0) begin errors++; $display("FAIL basic_err got %b need 0", er); end
`ifdef SCHED_PERF_CNT_EN
        checks++;
        if ({perf_tiles, perf_stall} !== {32'd8, 32'd0}) begin
            errors++; $display("FAIL basic_perf got %0d/%0d need 8/0", perf_tiles, perf_stall);
        end
`endif
    endtask

    task automatic test_single_6x6();
        int dc, ni, nr; bit er; tile_t lt;
        run_layer(6, 6, 1, 1'b0, -1, 0, 1'b0, dc, ni, nr, er, lt);
        checks++;
        if (dc != 4) begin errors++; $display("FAIL single_done_cycle got %0d need 4", dc); end
        checks++;
        if ((ni != 1) || (lt !== tile_t'(0))) begin
            errors++; $display("FAIL single_issue got n=%0d tile=%h need n=1 tile=0", ni, lt);
        end
    endtask

    task automatic test_zero_cfg();
        int dc, ni, nr; bit er; tile_t lt;
        run_layer(0, 8, 2, 1'b1, -1, 0, 1'b0, dc, ni, nr, er, lt);
        checks++;
        if ((dc != 1) || (er !== 1'b1)) begin
            errors++; $display("FAIL zero_h got cycle=%0d err=%b need cycle=1 err=1", dc, er);
        end
        checks++;
        if ((nr != 0) || (ni != 0)) begin
            errors++; $display("FAIL zero_h_req got req=%0d issue=%0d need 0/0", nr, ni);
        end
        run_layer(8, 8, 0, 1'b0, -1, 0, 1'b0, dc, ni, nr, er, lt);
        checks++;
        if ((dc != 1) || (er !== 1'b1) || (nr != 0)) begin
            errors++; $display("FAIL zero_od got cycle=%0d err=%b req=%0d need 1/1/0", dc, er, nr);
        end
    endtask

    task automatic test_stall();
        int dc, ni, nr; bit er; tile_t lt;
        run_layer(8, 8, 2, 1'b1, 1, 3, 1'b0, dc, ni, nr, er, lt);
        checks++;
        if (dc != 22) begin errors++; $display("FAIL stall_done_cycle got %0d need 22", dc); end
        checks++;
        if (ni != 8) begin errors++; $display("FAIL stall_issues got %0d need 8", ni); end
`ifdef SCHED_PERF_CNT_EN
        checks++;
        if ({perf_tiles, perf_stall} !== {32'd8, 32'd3}) begin
            errors++; $display("FAIL stall_perf got %0d/%0d need 8/3", perf_tiles, perf_stall);
        end
`endif
    endtask

    task automatic test_reset_mid_issue();
        int dc, ni, nr, seen; bit er, hit; tile_t lt;
        seen = 0; hit = 1'b0;
        @(negedge clk);
        bus.cfg_height = 9'd8; bus.cfg_width = 9'd8; bus.cfg_od = 8'd2; bus.cfg_size_type = 1'b1;
        bus.start = 1'b1; bus.wt_ack = 1'b1; bus.in_ack = 1'b1; bus.pe_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
            if (bus.pe_input_valid === 1'b1) begin
                if (seen == 0) begin
                    seen = 1; bus.pe_ready = 1'b1;
                end else begin
                    bus.pe_ready = 1'b0; hit = 1'b1;
                    break;
                end
            end
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL mid_issue_reach got none need second issue"); end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({bus.busy, bus.done, bus.err_cfg, bus.wt_req, bus.in_req,
             bus.pe_input_valid, bus.pe_weight_valid} !== 7'b0) begin
            errors++; $display("FAIL midrst_ctrl got nonzero need 0");
        end
        checks++;
        if ({bus.wt_od, bus.in_h_idx, bus.in_w_idx, bus.pe_height_index,
             bus.pe_width_index, bus.pe_od} !== '0) begin
            errors++; $display("FAIL midrst_idx got nonzero need 0");
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.done} !== 2'b00) begin
            errors++; $display("FAIL midrst_no_done got busy/done=%b need 00", {bus.busy, bus.done});
        end
        run_layer(8, 8, 1, 1'b1, -1, 0, 1'b0, dc, ni, nr, er, lt);
        checks++;
        if ((dc != 10) || (ni != 4)) begin
            errors++; $display("FAIL midrst_restart got cycle=%0d n=%0d need 10/4", dc, ni);
        end
    endtask

    task automatic test_back_to_back();
        int dc, ni, nr; bit er; tile_t lt;
        run_layer(12, 7, 3, 1'b0, -1, 0, 1'b1, dc, ni, nr, er, lt);
        checks++;
        if ((dc != 28) || (ni != 12)) begin
            errors++; $display("FAIL b2b_first got cycle=%0d n=%0d need 28/12", dc, ni);
        end
        run_layer(10, 10, 1, 1'b1, -1, 0, 1'b0, dc, ni, nr, er, lt);
        checks++;
        if ((dc != 20) || (ni != 9)) begin
            errors++; $display("FAIL b2b_second got cycle=%0d n=%0d need 20/9", dc, ni);
        end
    endtask

    task automatic test_max_size();
        int dc, ni, nr; bit er; tile_t lt;
        run_layer(511, 511, 1, 1'b1, -1, 0, 1'b0, dc, ni, nr, er, lt);
        checks++;
        if ((ni != 16384) || (dc != 32770)) begin
            errors++; $display("FAIL max_count got n=%0d cycle=%0d need 16384/32770", ni, dc);
        end
        checks++;
        if ({lt.h, lt.w} !== {9'd508, 9'd508}) begin
            errors++; $display("FAIL max_last_tile got h=%0d w=%0d need 508/508", lt.h, lt.w);
        end
    endtask

    initial begin
        test_reset();
        test_basic_3x3();
        test_single_6x6();
        test_zero_cfg();
        test_stall();
        test_reset_mid_issue();
        test_back_to_back();
        test_max_size();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout got running need finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
